hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage datapath; drives the hold/clear controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC write enable.
- Detects load-use hazards and inserts one bubble into ID_EX.
- Flushes IF_ID on a taken branch.
- Freezes the pipeline while a data-memory access is pending, with a timeout error.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_controller_pkg.sv | 33 +++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_controller.sv | 144 ++++++++++++++
 tb/tb_hazard_controller.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the pipeline-register control bundle and its canonical values.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_sync_clr;
        logic id_ex_hold;
        logic id_ex_sync_clr;
        logic ex_mem_hold;
        logic mem_wb_sync_clr;
    } ctrl_t;

    // Bit order follows the struct: pc, ifw, ifclr, idhold, idclr, exhold, memwbclr.
    localparam ctrl_t CTRL_NORMAL = ctrl_t'(7'b1100000);
    localparam ctrl_t CTRL_FLUSH  = ctrl_t'(7'b1110000);
    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(7'b0000100);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0001011);

    function automatic logic src_match(input logic [4:0] load_rt, input logic [4:0] src);
        return (load_rt == src);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    // Counter register: clear, saturating increment, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (clr) begin
            count <= {W{1'b0}};
        end else if (en && (count != MAX_VAL)) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes,
// data-memory freeze with timeout, and a stall-cycle counter.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             exMemToReg,
    input  logic [4:0]       exRt,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             stallCntClr,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             ifIdSyncClr,
    output logic             idExHold,
    output logic             idExSyncClr,
    output logic             exMemHold,
    output logic             memWbSyncClr,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);

    state_t            state_r;
    state_t            state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic              mem_timeout_r;
    logic              timeout_set_s;
    logic              mem_stall_s;
    logic              load_use_s;
    logic              stall_en_s;
    ctrl_t             ctrl_s;

    assign mem_stall_s = memReq & ~memReady;
    assign load_use_s  = exMemToReg & (exRt != REG_ZERO) &
                         (src_match(exRt, idRs) | (idUsesRt & src_match(exRt, idRt)));

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= RUN;
            wait_cnt_r    <= WAIT_ZERO;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            mem_timeout_r <= mem_timeout_r | timeout_set_s;
        end
    end

    // Next-state logic; a dropped memReq in MEM_WAIT counts as completion.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        timeout_set_s = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_s    = MEM_WAIT;
                    wait_cnt_s = WAIT_ONE;
                end else begin
                    wait_cnt_s = WAIT_ZERO;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall_s) begin
                    state_s    = RUN;
                    wait_cnt_s = WAIT_ZERO;
                end else if (wait_cnt_r == WAIT_LIMIT) begin
                    state_s       = ERROR;
                    timeout_set_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_ONE;
                end
            end
            ERROR: begin
                state_s = ERROR;
            end
            default: begin
                state_s    = RUN;
                wait_cnt_s = WAIT_ZERO;
            end
        endcase
    end

    // Pipeline controls; a taken branch under load-use is deferred to the re-resolve.
    always_comb begin
        ctrl_s = CTRL_NORMAL;
        if (!reset) begin
            ctrl_s = CTRL_NORMAL;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_stall_s) begin
                        ctrl_s = CTRL_FREEZE;
                    end else if (load_use_s) begin
                        ctrl_s = CTRL_BUBBLE;
                    end else if (branchTaken) begin
                        ctrl_s = CTRL_FLUSH;
                    end else begin
                        ctrl_s = CTRL_NORMAL;
                    end
                end
                MEM_WAIT: ctrl_s = CTRL_FREEZE;
                ERROR:    ctrl_s = CTRL_FREEZE;
                default:  ctrl_s = CTRL_FREEZE;
            endcase
        end
    end

    assign pcWrite      = ctrl_s.pc_write;
    assign ifIdWrite    = ctrl_s.if_id_write;
    assign ifIdSyncClr  = ctrl_s.if_id_sync_clr;
    assign idExHold     = ctrl_s.id_ex_hold;
    assign idExSyncClr  = ctrl_s.id_ex_sync_clr;
    assign exMemHold    = ctrl_s.ex_mem_hold;
    assign memWbSyncClr = ctrl_s.mem_wb_sync_clr;
    assign memTimeout   = mem_timeout_r;
    assign stall_en_s   = ~ctrl_s.pc_write;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clock),
        .rst_n (reset),
        .clr   (stallCntClr),
        .en    (stall_en_s),
        .count (stallCount)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// stimulus, compared every cycle against an episode-based behavioural model.
module tb_hazard_controller;

    localparam int TO   = 4;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    idRs = 5'd0, idRt = 5'd0, exRt = 5'd0;
    logic          idUsesRt = 1'b0, exMemToReg = 1'b0, branchTaken = 1'b0;
    logic          memReq = 1'b0, memReady = 1'b0, stallCntClr = 1'b0;
    logic          pcWrite, ifIdWrite, ifIdSyncClr, idExHold, idExSyncClr;
    logic          exMemHold, memWbSyncClr, memTimeout;
    logic [CW-1:0] stallCount;

    int total = 0;
    int bad   = 0;

    hazard_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemToReg(exMemToReg), .exRt(exRt), .branchTaken(branchTaken),
        .memReq(memReq), .memReady(memReady), .stallCntClr(stallCntClr),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdSyncClr(ifIdSyncClr),
        .idExHold(idExHold), .idExSyncClr(idExSyncClr), .exMemHold(exMemHold),
        .memWbSyncClr(memWbSyncClr), .memTimeout(memTimeout), .stallCount(stallCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a memory episode is a run of consecutive frozen cycles started by a stall.
    bit m_ep, m_err, m_tflag;
    int m_len, m_cnt;

    always @(negedge clock) begin : cmp
        bit ms, lu, fz, e_pc, e_flush, e_bub;
        #2;
        if (reset == 1'b0) begin
            m_ep = 0; m_err = 0; m_tflag = 0; m_len = 0; m_cnt = 0;
            ms = 0; lu = 0; fz = 0; e_pc = 1; e_flush = 0; e_bub = 0;
        end else begin
            ms = memReq && !memReady;
            lu = exMemToReg && (exRt != 5'd0) &&
                 ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
            fz = m_err || m_ep || ms;
            e_pc    = !fz && !lu;
            e_bub   = !fz && lu;
            e_flush = !fz && !lu && branchTaken;
        end
        chk("pcWrite",      32'(pcWrite),      32'(e_pc));
        chk("ifIdWrite",    32'(ifIdWrite),    32'(e_pc));
        chk("ifIdSyncClr",  32'(ifIdSyncClr),  32'(e_flush));
        chk("idExHold",     32'(idExHold),     32'(fz));
        chk("idExSyncClr",  32'(idExSyncClr),  32'(e_bub));
        chk("exMemHold",    32'(exMemHold),    32'(fz));
        chk("memWbSyncClr", 32'(memWbSyncClr), 32'(fz));
        chk("memTimeout",   32'(memTimeout),   32'(m_tflag));
        chk("stallCount",   32'(stallCount),   32'(m_cnt));
        if (reset == 1'b1) begin
            if (!m_err && (m_ep || ms)) begin
                m_len = m_ep ? m_len + 1 : 1;
                if (!ms) begin
                    m_ep = 0;
                end else if (m_len == TO + 1) begin
                    m_err = 1; m_tflag = 1; m_ep = 0;
                end else begin
                    m_ep = 1;
                end
            end
            if (stallCntClr) m_cnt = 0;
            else if (!e_pc) m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
        end
    end

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic mtr, input logic [4:0] ert, input logic br,
                        input logic mrq, input logic mrd, input logic clr);
        idRs = rs; idRt = rt; idUsesRt = ur; exMemToReg = mtr; exRt = ert;
        branchTaken = br; memReq = mrq; memReady = mrd; stallCntClr = clr;
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_count",   32'(stallCount), 32'd0);
        chk("rst_timeout", 32'(memTimeout), 32'd0);
        reset = 1'b1;
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // load-use on rs, then exRt=0 never stalls
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lu_rs_count", 32'(stallCount), 32'd1);
        step(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("r0_count", 32'(stallCount), 32'd1);
        // rt gated by idUsesRt
        step(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rt_off_count", 32'(stallCount), 32'd1);
        step(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rt_on_count", 32'(stallCount), 32'd2);
        // branch alone, then branch with load-use
        step(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd3, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("br_lu_count", 32'(stallCount), 32'd3);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_count", 32'(stallCount), 32'd0);
        // memory wait: 3 not-ready cycles then ready
        repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("memwait_count", 32'(stallCount), 32'd4);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("after_wait_count", 32'(stallCount), 32'd4);
        // saturation and clear-during-stall
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (9) step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_count", 32'(stallCount), 32'd7);
        step(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_stall_count", 32'(stallCount), 32'd0);
        // timeout into ERROR, which persists until reset
        repeat (4) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_timeout", 32'(memTimeout), 32'd0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout_set", 32'(memTimeout), 32'd1);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("error_sticky", 32'(memTimeout), 32'd1);
        chk("error_pc", 32'(pcWrite), 32'd0);
        reset = 1'b0;
        #1;
        chk("async_rst_timeout", 32'(memTimeout), 32'd0);
        chk("async_rst_pc",      32'(pcWrite),    32'd1);
        @(negedge clock);
        reset = 1'b1;
        // random traffic with occasional resets to leave ERROR
        repeat (3000) begin
            reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 19) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
